// File: rtl/prover_c012_sched_pkg.sv
// Shared types for the c012 job scheduler: field width, FSM encoding and
// the round-robin pointer increment.
package prover_c012_sched_pkg;

    localparam int F_NBITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    // Next round-robin start position after serving index w.
    function automatic int rr_inc(input int w, input int nreq);
        return (w + 1 >= nreq) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/prover_c012_sched_if.sv
// Requester and compute-unit signals of the c012 scheduler; the slave
// modport is the scheduler, the master modport is the surrounding system.
interface prover_c012_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]                                   req;
    logic [NREQ-1:0][2:0][prover_c012_sched_pkg::F_NBITS-1:0] fj_in;
    logic [NREQ-1:0]                                   ack;
    logic [2:0][prover_c012_sched_pkg::F_NBITS-1:0]    c_out;
    logic [IDW-1:0]                                    c_id;
    logic                                              c_valid;
    logic                                              busy;
    logic                                              cu_en;
    logic [2:0][prover_c012_sched_pkg::F_NBITS-1:0]    cu_fj;
    logic                                              cu_ready_pulse;
    logic [2:0][prover_c012_sched_pkg::F_NBITS-1:0]    cu_c;

    modport master (
        output req, fj_in, cu_ready_pulse, cu_c,
        input  ack, c_out, c_id, c_valid, busy, cu_en, cu_fj
    );

    modport slave (
        input  req, fj_in, cu_ready_pulse, cu_c,
        output ack, c_out, c_id, c_valid, busy, cu_en, cu_fj
    );
endinterface

// File: rtl/prover_c012_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping through NREQ-1 back to ptr-1.
module prover_c012_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  win,
    output logic            any
);
    // Doubling the vector lets a plain right shift perform the rotation.
    logic [2*NREQ-1:0] rot;

    always_comb begin
        int s;
        rot = {req, req} >> ptr;
        win = '0;
        any = 1'b0;
        s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                s   = int'(ptr) + i;
                if (s >= NREQ) s = s - NREQ;
                win = IDW'(s);
            end
        end
    end

endmodule

// File: rtl/prover_c012_sched.sv
// Round-robin scheduler sharing one c012 compute unit among NREQ requesters;
// one job in flight, operands and results passed through unmodified.
module prover_c012_sched
    import prover_c012_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstb,
    prover_c012_sched_if.slave bus
);

    sched_state_e                 state;
    logic [IDW-1:0]               ptr;
    logic [IDW-1:0]               win_id;
    logic                         busy_q;
    logic [IDW-1:0]               arb_win;
    logic                         arb_any;

    logic                         cu_en_p0;
    logic [2:0][F_NBITS-1:0]      cu_fj_p0;
    logic [2:0][F_NBITS-1:0]      c_out_p1;
    logic [IDW-1:0]               c_id_p1;
    logic                         c_valid_p1;
    logic [NREQ-1:0]              ack_p1;

    prover_c012_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .win (arb_win),
        .any (arb_any)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            win_id     <= '0;
            busy_q     <= 1'b0;
            cu_en_p0   <= 1'b0;
            cu_fj_p0   <= '0;
            c_out_p1   <= '0;
            c_id_p1    <= '0;
            c_valid_p1 <= 1'b0;
            ack_p1     <= '0;
        end else begin
            cu_en_p0   <= 1'b0;
            c_valid_p1 <= 1'b0;
            ack_p1     <= '0;
            case (state)
                // Grant stage: the ack cycle is skipped so a requester still
                // holding req while seeing its ack is not served twice.
                ST_IDLE: begin
                    if (arb_any && !c_valid_p1) begin
                        win_id   <= arb_win;
                        cu_fj_p0 <= bus.fj_in[arb_win];
                        cu_en_p0 <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                // Completion stage: result, owner and ack are registered together.
                ST_WAIT: begin
                    if (bus.cu_ready_pulse) begin
                        c_out_p1   <= bus.cu_c;
                        c_id_p1    <= win_id;
                        c_valid_p1 <= 1'b1;
                        ack_p1     <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                        ptr        <= IDW'(rr_inc(int'(win_id), NREQ));
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cu_en   = cu_en_p0;
    assign bus.cu_fj   = cu_fj_p0;
    assign bus.c_out   = c_out_p1;
    assign bus.c_id    = c_id_p1;
    assign bus.c_valid = c_valid_p1;
    assign bus.ack     = ack_p1;
    assign bus.busy    = busy_q;

endmodule
